pe_psum_drain: RTL
==================

Name: pe_psum_drain

Overview:
- Consumer end of the PE block output interface.
- Each PE pass delivers 7 rows of 32-bit partial sums. A pass is 4 MACs per row, seeded with the bias.
- This block accumulates those partial sums over a configurable number of passes, so dot products longer than 4 are possible. It then streams the 7 finished row results, one per beat, to the downstream requant/writeback stage over a valid/ready handshake.

Parameters:
- ROWS, 7, PE rows per pass; one result per row.
- ACC_W, 32, partial-sum and accumulator width.
- PASS_W, 8, width of the pass-count configuration.
- ROW_W, 3, width of the row index; must satisfy 2^ROW_W >= ROWS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- cfg_passes  input  PASS_W  passes per tile; latched on the first accepted beat of a tile; 0 is treated as 1.
- pe_valid  input  1  pe_out holds a valid pass result.
- pe_ready  output  1  block can accept a pass result.
- pe_out  input  ROWS*ACC_W  packed PE outputs; row r at [r*ACC_W +: ACC_W].
- res_valid  output  1  res_data holds a finished row result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  ACC_W  accumulated result for row res_row.
- res_row  output  ROW_W  row index of res_data, 0..ROWS-1.
- res_last  output  1  high on the beat for row ROWS-1.
- busy  output  1  tile in progress (pass_cnt != 0 or in DRAIN).

Behaviour:
- Reset (async, active-high) sets:
  - state = ACCUM; pass_cnt = 0; passes_q = 1; row_idx = 0.
  - all acc[r] = 0.
  - Outputs: pe_ready = 1, res_valid = 0, res_data = 0, res_row = 0, res_last = 0, busy = 0.
- Reset asserted mid-tile or mid-drain discards all state. No result beat is emitted after reset deasserts until a new tile completes.
- State ACCUM:
  - pe_ready = 1, res_valid = 0.
  - Accept = pe_valid && pe_ready.
  - On accept with pass_cnt == 0:
    - acc[r] <= pe_out row r, for all r (overwrite; no stale sum survives).
    - passes_q <= max(cfg_passes, 1).
  - On accept with pass_cnt != 0: acc[r] <= acc[r] + pe_out row r, two's complement, wrapping modulo 2^ACC_W. No saturation, no overflow flag.
  - Pass completion is judged against the effective pass count: passes_q, or max(cfg_passes, 1) on the first beat.
    - If the accept is the last pass (pass_cnt == effective count - 1): next state DRAIN, row_idx <= 0, pass_cnt <= 0.
    - Otherwise pass_cnt <= pass_cnt + 1.
  - cfg_passes changes while pass_cnt != 0 are ignored.
- State DRAIN:
  - pe_ready = 0; pe_valid is ignored and the PE side stalls.
  - res_valid = 1, res_data = acc[row_idx], res_row = row_idx, res_last = (row_idx == ROWS-1).
  - All four are registered or driven directly from registered state; no combinational path from pe_* to res_*.
  - res_ready low: hold res_data, res_row and res_last stable.
  - res_ready high and not last row: row_idx <= row_idx + 1.
  - res_ready high and last row: state <= ACCUM, row_idx <= 0. pe_ready rises the following cycle; no same-cycle accept on the handoff.
- Latency:
  - The accept edge of the final pass moves the block to DRAIN; res_valid is high in the next cycle.
  - With res_ready held high, the 7 results appear on 7 consecutive cycles.
  - Minimum tile period is passes + ROWS cycles.
- Single-pass tiles (cfg_passes = 0 or 1) go to DRAIN directly after one accept.
- busy = (state == DRAIN) || (pass_cnt != 0).

Test Plan:
- Reset, then cfg_passes = 1, one beat with row r = r+1 -> res_data 1,2,...,7 on 7 consecutive cycles with res_ready = 1; res_row 0..6; res_last only with row 6; pe_ready low for exactly 7 cycles.
- cfg_passes = 3, rows all 10, then 20, then -5 (0xFFFFFFFB) -> every res_data = 25; busy high from the first accept through the last drain beat.
- Wrap: cfg_passes = 2, row 0 = 0x7FFFFFFF, then 0x00000002 -> res_data row 0 = 0x80000001.
- Backpressure: during DRAIN toggle res_ready 1,0,0,1,... -> res_data and res_row stable while stalled; each row emitted exactly once, in order; pe_valid held high throughout is not accepted.
- cfg_passes = 0 -> behaves as 1. Change cfg_passes from 2 to 5 after the first accept -> tile still completes after 2 passes.
- Assert rst during DRAIN at row 3 -> res_valid = 0 and acc cleared immediately. Next tile with cfg_passes = 1 and rows all 4 -> all results = 4; no leftover rows 4..6 from the old tile.

Source files
------------

// File: rtl/pe_psum_drain.sv
// ---------------------------------------------------------------------------
// pe_psum_drain
//
// Consumer end of the PE block output interface. Each accepted PE beat
// carries one pass worth of partial sums for ROWS rows. The block sums those
// beats over a configurable number of passes. It then streams the finished
// per-row totals, one row per beat, to the downstream requant/writeback
// stage.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   cfg_passes  passes per tile, latched on the first beat of a tile (0 -> 1)
//   pe_valid    pe_out carries a valid pass result
//   pe_ready    block can accept a pass result (high only while accumulating)
//   pe_out      packed partial sums, row r at [r*ACC_W +: ACC_W]
//   res_valid   res_data carries a finished row result
//   res_ready   downstream accepts the current result beat
//   res_data    accumulated total for row res_row
//   res_row     row index of res_data
//   res_last    high on the beat for row ROWS-1
//   busy        a tile is in progress (mid-accumulation or draining)
// ---------------------------------------------------------------------------
module pe_psum_drain #(
    parameter int ROWS   = 7,
    parameter int ACC_W  = 32,
    parameter int PASS_W = 8,
    parameter int ROW_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PASS_W-1:0]     cfg_passes,
    input  logic                  pe_valid,
    output logic                  pe_ready,
    input  logic [ROWS*ACC_W-1:0] pe_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_W-1:0]      res_data,
    output logic [ROW_W-1:0]      res_row,
    output logic                  res_last,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_reg;
    logic [PASS_W-1:0] pass_cnt_reg;
    logic [PASS_W-1:0] passes_q_reg;
    logic [ROW_W-1:0]  row_idx_reg;
    logic              pe_ready_reg;
    logic              res_valid_reg;
    logic              res_last_reg;

    // Per-row accumulator read-back, one entry per generated row register.
    logic [ACC_W-1:0]  acc_rd [ROWS];

    logic              accept;
    logic              first_beat;
    logic [PASS_W-1:0] cfg_eff;
    logic [PASS_W-1:0] eff_passes;
    logic              last_pass;
    logic              last_row;
    logic [ROW_W-1:0]  row_idx_next;

    // PE side is only ever ready while accumulating, so the accept qualifier
    // comes straight from the state register.
    assign accept     = pe_valid && (state_reg == ACCUM);
    assign first_beat = (pass_cnt_reg == '0);

    // A zero pass count would never complete a tile; treat it as one pass.
    assign cfg_eff    = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;

    // On the first beat the latched count is not yet valid, so completion is
    // judged against the live configuration instead.
    assign eff_passes = first_beat ? cfg_eff : passes_q_reg;
    assign last_pass  = (pass_cnt_reg == (eff_passes - PASS_W'(1)));

    assign row_idx_next = row_idx_reg + ROW_W'(1);
    assign last_row     = (row_idx_reg == ROW_W'(ROWS - 1));

    // -----------------------------------------------------------------------
    // Control FSM: pass counting, drain sequencing and handshake outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ACCUM;
            pass_cnt_reg  <= '0;
            passes_q_reg  <= PASS_W'(1);
            row_idx_reg   <= '0;
            pe_ready_reg  <= 1'b1;
            res_valid_reg <= 1'b0;
            res_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (first_beat) begin
                            passes_q_reg <= cfg_eff;
                        end
                        if (last_pass) begin
                            state_reg     <= DRAIN;
                            pass_cnt_reg  <= '0;
                            row_idx_reg   <= '0;
                            pe_ready_reg  <= 1'b0;
                            res_valid_reg <= 1'b1;
                            res_last_reg  <= (ROWS == 1);
                        end else begin
                            pass_cnt_reg <= pass_cnt_reg + PASS_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (last_row) begin
                            // pe_ready rises only after this edge, so no PE
                            // beat can be taken on the handoff cycle.
                            state_reg     <= ACCUM;
                            row_idx_reg   <= '0;
                            pe_ready_reg  <= 1'b1;
                            res_valid_reg <= 1'b0;
                            res_last_reg  <= 1'b0;
                        end else begin
                            row_idx_reg  <= row_idx_next;
                            res_last_reg <= (row_idx_next == ROW_W'(ROWS - 1));
                        end
                    end
                end
                default: begin
                    state_reg <= ACCUM;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Row accumulators. The first beat of a tile overwrites, so nothing from
    // a previous tile can leak into a new sum. Addition wraps at ACC_W bits.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_acc
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] pe_row;

            assign pe_row     = pe_out[gi*ACC_W +: ACC_W];
            assign acc_rd[gi] = acc_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= first_beat ? pe_row : (acc_reg + pe_row);
                end
            end
        end
    endgenerate

    // Result side is driven only from registered state; pe_* inputs have no
    // combinational path to it. Accumulators are frozen during DRAIN, so the
    // selected value stays put while the downstream stalls.
    assign pe_ready  = pe_ready_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = acc_rd[row_idx_reg];
    assign res_row   = row_idx_reg;
    assign res_last  = res_last_reg;
    assign busy      = (state_reg == DRAIN) || (pass_cnt_reg != '0);

endmodule
